lane_serializer: RTL and testbench

Accepts one packed two-dimensional word of N lanes by W bits and emits it one lane per cycle on a valid/ready stream. Lane order is selectable per transaction: MSB-lane first or LSB-lane first. An optional per-lane bit reversal is also selectable per transaction. Sits between wide datapath blocks and narrow lane-serial consumers (packers, link layers) and generalises fixed-index MSB/LSB lane selection into a parametrised, flow-controlled unit.

---
 rtl/lane_serializer_pkg.sv | 31 +++
 rtl/lane_serializer_if.sv | 37 +++
 rtl/lane_mux.sv | 28 ++
 rtl/lane_serializer.sv | 120 ++++++++++++
 tb/tb_lane_serializer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_serializer_pkg.sv
// Shared types and helpers for the lane serializer and its deserializer counterpart.
package lane_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Widest lane the generic bit_reverse helper supports; lanes are zero-extended into it.
  localparam int unsigned MaxLaneW    = 256;
  localparam int unsigned MaxLaneIdxW = $clog2(MaxLaneW);

  // A count of 0 or anything beyond the lane count means "all lanes".
  function automatic int unsigned effective_count(input int unsigned count, input int unsigned n);
    return ((count == 0) || (count > n)) ? n : count;
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MaxLaneW-1:0] bit_reverse(input logic [MaxLaneW-1:0] v,
                                                      input int unsigned       w);
    logic [MaxLaneW-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < MaxLaneW; j++) begin
      if (j < w) begin
        r[MaxLaneIdxW'(j)] = v[MaxLaneIdxW'(w - 1 - j)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_serializer_if.sv
// Word-in / lane-out stream bundle. The serializer sits on the slave side; whoever feeds
// words and consumes lanes sits on the master side.
interface lane_serializer_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);

  localparam int unsigned CW = $clog2(N + 1);

  // Word side
  logic                  i_valid;
  logic                  o_ready;
  logic [N-1:0][W-1:0]   i_data;
  logic [CW-1:0]         i_count;
  logic                  i_msb_first;
  logic                  i_bit_rev;

  // Lane side
  logic                  o_valid;
  logic                  i_ready;
  logic [W-1:0]          o_data;
  logic                  o_last;

  // Status
  logic                  o_busy;

  modport slave (
    input  i_valid, i_data, i_count, i_msb_first, i_bit_rev, i_ready,
    output o_ready, o_valid, o_data, o_last, o_busy
  );

  modport master (
    output i_valid, i_data, i_count, i_msb_first, i_bit_rev, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_busy
  );

endinterface

// File: rtl/lane_mux.sv
// Combinational lane picker: selects the k-th lane of a packed word in either order and
// optionally mirrors its bits. Shared with the deserializer.
module lane_mux
  import lane_serializer_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic [N-1:0][W-1:0]     i_data,
  input  logic [$clog2(N+1)-1:0]  i_idx,
  input  logic                    i_msb_first,
  input  logic                    i_bit_rev,
  output logic [W-1:0]            o_lane
);

  localparam int unsigned LaneIdxW = (N > 1) ? $clog2(N) : 1;

  logic [LaneIdxW-1:0] w_sel;
  logic [W-1:0]        w_lane;

  // Map the emission index onto a physical lane and apply the optional bit mirror.
  always_comb begin
    w_sel  = LaneIdxW'(i_msb_first ? (N - 1 - 32'(i_idx)) : 32'(i_idx));
    w_lane = i_data[w_sel];
    o_lane = i_bit_rev ? W'(bit_reverse(MaxLaneW'(w_lane), W)) : w_lane;
  end

endmodule

// File: rtl/lane_serializer.sv
// Emits an N-lane word one lane per cycle on a valid/ready stream, MSB- or LSB-lane first,
// with optional per-lane bit reversal. A new word can be taken on the last lane's handshake,
// so back-to-back words stream with no bubble.
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  lane_serializer_if.slave   bus
);

  localparam int unsigned CW = $clog2(N + 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [N-1:0][W-1:0] r_data;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       r_k;
  logic [CW-1:0]       w_k_nxt;
  logic                r_msb_first;
  logic                r_bit_rev;

  logic                w_valid;
  logic                w_last;
  logic                w_out_hs;
  logic                w_ready;
  logic                w_accept;
  logic                w_load;
  logic [CW-1:0]       w_cnt_eff;
  logic [W-1:0]        w_lane;

  // Handshake terms; o_ready looks at i_ready so a new word can ride the last lane's handshake.
  always_comb begin
    w_valid   = (r_state == SEND);
    w_last    = w_valid && (r_k == (r_cnt - CW'(1)));
    w_out_hs  = w_valid && bus.i_ready;
    w_ready   = (r_state == IDLE) || (w_out_hs && w_last);
    w_accept  = bus.i_valid && w_ready;
    w_cnt_eff = CW'(effective_count(32'(bus.i_count), N));
  end

  // Next-state and lane index.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SEND;
          w_load      = 1'b1;
          w_k_nxt     = '0;
        end
      end
      SEND: begin
        if (w_out_hs) begin
          if (w_last) begin
            if (w_accept) begin
              w_load  = 1'b1;
              w_k_nxt = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_k_nxt = r_k + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and lane index registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Capture the word and its per-transaction controls on accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data      <= '0;
      r_cnt       <= '0;
      r_msb_first <= 1'b0;
      r_bit_rev   <= 1'b0;
    end else if (w_load) begin
      r_data      <= bus.i_data;
      r_cnt       <= w_cnt_eff;
      r_msb_first <= bus.i_msb_first;
      r_bit_rev   <= bus.i_bit_rev;
    end
  end

  lane_mux #(
    .N (N),
    .W (W)
  ) u_lane_mux (
    .i_data      (r_data),
    .i_idx       (r_k),
    .i_msb_first (r_msb_first),
    .i_bit_rev   (r_bit_rev),
    .o_lane      (w_lane)
  );

  assign bus.o_valid = w_valid;
  assign bus.o_ready = w_ready;
  assign bus.o_last  = w_last;
  // Data is forced to zero while idle so the bus reads clean after reset or a drain.
  assign bus.o_data  = w_valid ? w_lane : '0;
  assign bus.o_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: directed cases plus randomized words, all checked against a
// transaction-level model that expands each accepted word into its expected lane list.
module tb_lane_serializer;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(N + 1);

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } lane_t;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  int   ready_mode = 0;
  int   cyc = 0;

  lane_t        exp_q[$];
  logic [W-1:0] got_q[$];
  logic         gotl_q[$];
  int           cyc_q[$];

  lane_serializer_if #(.N(N), .W(W)) bus ();

  lane_serializer #(
    .N (N),
    .W (W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a word becomes an ordered list of lanes straight from the selection rules.
  function automatic void model_push(input logic [N-1:0][W-1:0] d, input int unsigned cnt_in,
                                     input bit msb, input bit rev);
    int unsigned  cnt;
    lane_t        ln;
    logic [W-1:0] v;
    cnt = ((cnt_in == 0) || (cnt_in > N)) ? N : cnt_in;
    for (int unsigned k = 0; k < cnt; k++) begin
      v = msb ? d[N - 1 - k] : d[k];
      ln.data = v;
      if (rev) begin
        for (int j = 0; j < int'(W); j++) ln.data[j] = v[W - 1 - j];
      end
      ln.last = (k == cnt - 1);
      exp_q.push_back(ln);
    end
  endfunction

  // Monitor: compare outputs each cycle against the model, then apply the edge's handshakes.
  always @(negedge clk) begin
    logic e_valid, e_last, e_ready;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      e_valid = (exp_q.size() > 0);
      e_last  = e_valid ? exp_q[0].last : 1'b0;
      e_ready = !e_valid || (bus.i_ready && e_last);
      check_eq("o_valid", bus.o_valid, e_valid);
      check_eq("o_busy", bus.o_busy, e_valid);
      check_eq("o_ready", bus.o_ready, e_ready);
      if (e_valid) begin
        check_eq("o_data", bus.o_data, exp_q[0].data);
        check_eq("o_last", bus.o_last, e_last);
        if (bus.i_ready) begin
          got_q.push_back(bus.o_data);
          gotl_q.push_back(bus.o_last);
          cyc_q.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
      if (bus.i_valid && e_ready) begin
        model_push(bus.i_data, 32'(bus.i_count), bus.i_msb_first, bus.i_bit_rev);
      end
    end
  end

  // Downstream ready generator: always, 1-0-0 pattern, or random.
  initial begin
    int rc = 0;
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = (rc % 3 == 0);
        default: bus.i_ready = ($urandom_range(0, 3) != 0);
      endcase
      rc++;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_word(input logic [N*W-1:0] d, input int cnt, input bit msb, input bit rev);
    bit acc = 1'b0;
    bus.i_data      = d;
    bus.i_count     = CW'(cnt);
    bus.i_msb_first = msb;
    bus.i_bit_rev   = rev;
    bus.i_valid     = 1'b1;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      #1;
      if (bus.o_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq("accept_timeout", acc, 1'b1);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int c = 0; c < 200 && !idle; c++) begin
      @(negedge clk);
      #1;
      if (!bus.o_busy && exp_q.size() == 0) idle = 1'b1;
    end
    check_eq({tag, "_idle"}, idle, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_q.delete();
    gotl_q.delete();
    cyc_q.delete();
  endtask

  // Expected lanes listed first-emitted in the top byte of the n-lane field.
  task automatic expect_lanes(input string tag, input int n, input logic [63:0] exp_lanes,
                              input logic [7:0] last_mask);
    check_eq({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check_eq({tag, "_data"}, got_q[i], exp_lanes[(n - 1 - i) * 8 +: 8]);
      check_eq({tag, "_last"}, gotl_q[i], last_mask[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=%0d expected=0 pending", n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*W-1:0] word;
    word            = 32'hD3C2_B1A0;
    rst             = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_count     = '0;
    bus.i_msb_first = 1'b0;
    bus.i_bit_rev   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_o_valid", bus.o_valid, 1'b0);
    check_eq("rst_o_ready", bus.o_ready, 1'b1);
    check_eq("rst_o_last", bus.o_last, 1'b0);
    check_eq("rst_o_busy", bus.o_busy, 1'b0);
    check_eq("rst_o_data", bus.o_data, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: full word, MSB lane first
    clear_log();
    send_word(word, 4, 1'b1, 1'b0);
    wait_idle("t1");
    expect_lanes("t1", 4, 64'hD3C2_B1A0, 8'b1000);

    // 2: LSB first, two lanes
    clear_log();
    send_word(word, 2, 1'b0, 1'b0);
    wait_idle("t2");
    expect_lanes("t2", 2, 64'hA0B1, 8'b10);

    // 3: single lane with bit reversal
    clear_log();
    send_word(word, 1, 1'b1, 1'b1);
    wait_idle("t3");
    expect_lanes("t3", 1, 64'hCB, 8'b1);

    // 4: stalling downstream
    clear_log();
    ready_mode = 1;
    send_word(word, 4, 1'b1, 1'b0);
    wait_idle("t4");
    expect_lanes("t4", 4, 64'hD3C2_B1A0, 8'b1000);
    ready_mode = 0;
    @(posedge clk);
    #1;

    // 5: back-to-back words, no bubble
    clear_log();
    send_word(word, 4, 1'b1, 1'b0);
    send_word(32'h4433_2211, 4, 1'b0, 1'b0);
    wait_idle("t5");
    expect_lanes("t5", 8, 64'hD3C2_B1A0_1122_3344, 8'b1000_1000);
    if (cyc_q.size() >= 8) check_eq("t5_nobubble", cyc_q[7] - cyc_q[0], 7);

    // 6: out-of-range counts clamp to N
    clear_log();
    send_word(word, 0, 1'b0, 1'b0);
    wait_idle("t6a");
    expect_lanes("t6a", 4, 64'hA0B1_C2D3, 8'b1000);
    clear_log();
    send_word(word, 7, 1'b1, 1'b0);
    wait_idle("t6b");
    expect_lanes("t6b", 4, 64'hD3C2_B1A0, 8'b1000);

    // 6: reset after the second lane drops the rest immediately
    clear_log();
    send_word(word, 4, 1'b1, 1'b0);
    for (int c = 0; c < 50 && got_q.size() < 2; c++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_o_valid", bus.o_valid, 1'b0);
    check_eq("rst_mid_o_ready", bus.o_ready, 1'b1);
    check_eq("rst_mid_o_busy", bus.o_busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_lanes("t6r", 2, 64'hD3C2, 8'b00);
    clear_log();
    send_word(32'h4433_2211, 4, 1'b0, 1'b0);
    wait_idle("t6n");
    expect_lanes("t6n", 4, 64'h1122_3344, 8'b1000);

    // Random words, random downstream stalls, mixed gaps and back-to-back
    ready_mode = 2;
    for (int t = 0; t < 60; t++) begin
      send_word($urandom, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle("rand");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
